// File: rtl/lights_pkg.sv
// Shared encodings for the turn-signal controller; the FSM state doubles as the MODE output.
package lights_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_LEFT  = 2'd1,
    MODE_RIGHT = 2'd2,
    MODE_HAZ   = 2'd3
  } mode_e;

endpackage

// File: rtl/seq_turn_signal_step_tick_gen.sv
// Free-running step timer: counts 0..STEP_CYCLES-1 and flags the last count as a one-cycle tick.
module step_tick_gen #(
  parameter int STEP_CYCLES = 16777216
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/seq_turn_signal.sv
// Sequential turn-signal / hazard lamp controller with synchronised switch inputs and brake overlay.
// MODE is the registered FSM state and serves as the state debug view.
module seq_turn_signal
  import lights_pkg::*;
#(
  parameter int LAMPS       = 3,
  parameter int STEP_CYCLES = 16777216
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LEFT_N,
  input  logic             RIGHT_N,
  input  logic             HAZ_N,
  input  logic             BRAKE,
  output logic [LAMPS-1:0] LAMP_L,
  output logic [LAMPS-1:0] LAMP_R,
  output logic [1:0]       MODE,
  output logic             STEP
);

  localparam int               KW     = $clog2(LAMPS + 2);
  localparam logic [KW-1:0]    K_ONE  = KW'(1);
  localparam logic [KW-1:0]    K_OFF  = KW'(LAMPS + 1);
  localparam logic [LAMPS-1:0] ALL_ON = '1;

  logic [1:0] r_left_sync, r_right_sync, r_haz_sync, r_brake_sync;
  logic       w_left_s, w_right_s, w_haz_s, w_brake_s;
  logic       w_haz_req, w_left_req, w_right_req, w_any_req;
  logic       w_tick, w_clear;
  logic [KW-1:0] w_k_next;
  logic       w_brake_l, w_brake_r;

  mode_e            r_state;
  logic [KW-1:0]    r_k;
  logic             r_haz_on;
  logic [LAMPS-1:0] r_lamp_l, r_lamp_r;
  logic             r_step;

  // Synchronisers store requests as active-high.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_left_sync  <= '0;
      r_right_sync <= '0;
      r_haz_sync   <= '0;
      r_brake_sync <= '0;
    end else begin
      r_left_sync  <= {r_left_sync[0],  ~LEFT_N};
      r_right_sync <= {r_right_sync[0], ~RIGHT_N};
      r_haz_sync   <= {r_haz_sync[0],   ~HAZ_N};
      r_brake_sync <= {r_brake_sync[0], BRAKE};
    end
  end

  assign w_left_s  = r_left_sync[1];
  assign w_right_s = r_right_sync[1];
  assign w_haz_s   = r_haz_sync[1];
  assign w_brake_s = r_brake_sync[1];

  // Both sides held together counts as hazard.
  assign w_haz_req   = w_haz_s | (w_left_s & w_right_s);
  assign w_left_req  = w_left_s & ~w_haz_req;
  assign w_right_req = w_right_s & ~w_haz_req;
  assign w_any_req   = w_haz_req | w_left_req | w_right_req;

  assign w_clear  = (r_state == MODE_IDLE) && w_any_req;
  assign w_k_next = (r_k == K_OFF) ? K_ONE : r_k + 1'b1;

  step_tick_gen #(.STEP_CYCLES(STEP_CYCLES)) u_tick (
    .CLK   (CLK),
    .RESET (RESET),
    .clear (w_clear),
    .tick  (w_tick)
  );

  function automatic logic [LAMPS-1:0] sweep_mask(input logic [KW-1:0] k);
    logic [LAMPS-1:0] m;
    for (int i = 0; i < LAMPS; i++) begin
      m[i] = (k > KW'(i)) && (k <= KW'(LAMPS));
    end
    return m;
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= MODE_IDLE;
      r_k      <= '0;
      r_haz_on <= 1'b0;
      r_lamp_l <= '0;
      r_lamp_r <= '0;
      r_step   <= 1'b0;
    end else begin
      r_step <= 1'b0;
      case (r_state)
        MODE_IDLE: begin
          r_lamp_l <= '0;
          r_lamp_r <= '0;
          r_k      <= '0;
          if (w_haz_req) begin
            r_state  <= MODE_HAZ;
            r_haz_on <= 1'b1;
            r_lamp_l <= ALL_ON;
            r_lamp_r <= ALL_ON;
            r_step   <= 1'b1;
          end else if (w_left_req) begin
            r_state  <= MODE_LEFT;
            r_k      <= K_ONE;
            r_lamp_l <= sweep_mask(K_ONE);
            r_step   <= 1'b1;
          end else if (w_right_req) begin
            r_state  <= MODE_RIGHT;
            r_k      <= K_ONE;
            r_lamp_r <= sweep_mask(K_ONE);
            r_step   <= 1'b1;
          end
        end

        MODE_LEFT: if (w_tick) begin
          r_step <= 1'b1;
          if (w_haz_req) begin
            r_state  <= MODE_HAZ;
            r_haz_on <= 1'b1;
            r_k      <= '0;
            r_lamp_l <= ALL_ON;
            r_lamp_r <= ALL_ON;
          end else if (w_right_req) begin
            r_state  <= MODE_RIGHT;
            r_k      <= K_ONE;
            r_lamp_l <= '0;
            r_lamp_r <= sweep_mask(K_ONE);
          end else if (w_left_req) begin
            r_k      <= w_k_next;
            r_lamp_l <= sweep_mask(w_k_next);
            r_lamp_r <= '0;
          end else begin
            r_state  <= MODE_IDLE;
            r_k      <= '0;
            r_lamp_l <= '0;
            r_lamp_r <= '0;
          end
        end

        MODE_RIGHT: if (w_tick) begin
          r_step <= 1'b1;
          if (w_haz_req) begin
            r_state  <= MODE_HAZ;
            r_haz_on <= 1'b1;
            r_k      <= '0;
            r_lamp_l <= ALL_ON;
            r_lamp_r <= ALL_ON;
          end else if (w_left_req) begin
            r_state  <= MODE_LEFT;
            r_k      <= K_ONE;
            r_lamp_l <= sweep_mask(K_ONE);
            r_lamp_r <= '0;
          end else if (w_right_req) begin
            r_k      <= w_k_next;
            r_lamp_l <= '0;
            r_lamp_r <= sweep_mask(w_k_next);
          end else begin
            r_state  <= MODE_IDLE;
            r_k      <= '0;
            r_lamp_l <= '0;
            r_lamp_r <= '0;
          end
        end

        MODE_HAZ: if (w_tick) begin
          r_step <= 1'b1;
          // Exit is only considered from the dark phase so a flash is never cut short.
          if (r_haz_on) begin
            r_haz_on <= 1'b0;
            r_lamp_l <= '0;
            r_lamp_r <= '0;
          end else if (w_haz_req) begin
            r_haz_on <= 1'b1;
            r_lamp_l <= ALL_ON;
            r_lamp_r <= ALL_ON;
          end else if (w_left_req) begin
            r_state  <= MODE_LEFT;
            r_k      <= K_ONE;
            r_lamp_l <= sweep_mask(K_ONE);
            r_lamp_r <= '0;
          end else if (w_right_req) begin
            r_state  <= MODE_RIGHT;
            r_k      <= K_ONE;
            r_lamp_l <= '0;
            r_lamp_r <= sweep_mask(K_ONE);
          end else begin
            r_state  <= MODE_IDLE;
            r_lamp_l <= '0;
            r_lamp_r <= '0;
          end
        end
      endcase
    end
  end

  // Brake lights any side that is not currently signalling; hazard ignores it.
  assign w_brake_l = w_brake_s && (r_state == MODE_IDLE || r_state == MODE_RIGHT);
  assign w_brake_r = w_brake_s && (r_state == MODE_IDLE || r_state == MODE_LEFT);

  assign LAMP_L = r_lamp_l | {LAMPS{w_brake_l}};
  assign LAMP_R = r_lamp_r | {LAMPS{w_brake_r}};
  assign MODE   = r_state;
  assign STEP   = r_step;

endmodule

// File: tb/tb_seq_turn_signal.sv
// Directed bench for seq_turn_signal (LAMPS=3, STEP_CYCLES=4): expected lamp states are queued
// as requests are driven and compared on each STEP pulse.
module tb_seq_turn_signal;
  import lights_pkg::*;

  localparam int LAMPS       = 3;
  localparam int STEP_CYCLES = 4;

  logic             CLK     = 1'b0;
  logic             RESET   = 1'b1;
  logic             LEFT_N  = 1'b1;
  logic             RIGHT_N = 1'b1;
  logic             HAZ_N   = 1'b1;
  logic             BRAKE   = 1'b0;
  logic [LAMPS-1:0] LAMP_L;
  logic [LAMPS-1:0] LAMP_R;
  logic [1:0]       MODE;
  logic             STEP;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  logic [7:0] exp_q[$];

  // Clock / reset
  always #5 CLK = ~CLK;

  seq_turn_signal #(.LAMPS(LAMPS), .STEP_CYCLES(STEP_CYCLES)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .LEFT_N  (LEFT_N),
    .RIGHT_N (RIGHT_N),
    .HAZ_N   (HAZ_N),
    .BRAKE   (BRAKE),
    .LAMP_L  (LAMP_L),
    .LAMP_R  (LAMP_R),
    .MODE    (MODE),
    .STEP    (STEP)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] m, input logic [2:0] l, input logic [2:0] r);
    exp_q.push_back({m, l, r});
  endtask

  task automatic wait_step(input int budget, output int waited, output bit ok);
    waited = 0;
    ok     = 1'b0;
    while (waited < budget && !ok) begin
      @(negedge CLK);
      waited++;
      if (STEP === 1'b1) ok = 1'b1;
    end
  endtask

  // Pops one expectation per STEP pulse and checks lamps/mode plus cycles since the previous pulse.
  task automatic expect_steps(input string tag, input int n, input int gap);
    int         w;
    bit         ok;
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      wait_step(12, w, ok);
      chk({tag, "_seen"}, 16'(ok), 16'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      if (ok) begin
        chk(tag, 16'({MODE, LAMP_L, LAMP_R}), 16'(e));
        chk({tag, "_gap"}, 16'(w), 16'(gap));
      end
    end
  endtask

  initial begin
    // 1: reset, then a dark idle period
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_out", 16'({MODE, LAMP_L, LAMP_R, STEP}), 16'd0);
    RESET = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("idle_dark", 16'({MODE, LAMP_L, LAMP_R, STEP}), 16'd0);
    end

    // 2: left sweep with wrap, then release
    push(MODE_LEFT, 3'b001, 3'b000);
    LEFT_N = 1'b0;
    expect_steps("left_first", 1, 3);
    push(MODE_LEFT, 3'b011, 3'b000);
    push(MODE_LEFT, 3'b111, 3'b000);
    push(MODE_LEFT, 3'b000, 3'b000);
    push(MODE_LEFT, 3'b001, 3'b000);
    expect_steps("left_sweep", 4, 4);
    LEFT_N = 1'b1;
    push(MODE_IDLE, 3'b000, 3'b000);
    expect_steps("left_release", 1, 4);
    repeat (5) @(negedge CLK);

    // 3: right sweep, left added mid-sweep becomes hazard
    RIGHT_N = 1'b0;
    push(MODE_RIGHT, 3'b000, 3'b001);
    expect_steps("right_first", 1, 3);
    push(MODE_RIGHT, 3'b000, 3'b011);
    expect_steps("right_sweep", 1, 4);
    LEFT_N = 1'b0;
    push(MODE_HAZ, 3'b111, 3'b111);
    push(MODE_HAZ, 3'b000, 3'b000);
    push(MODE_HAZ, 3'b111, 3'b111);
    expect_steps("haz_lr", 3, 4);

    // 4: hand over to HAZ_N, then release it during the all-on phase
    HAZ_N   = 1'b0;
    LEFT_N  = 1'b1;
    RIGHT_N = 1'b1;
    push(MODE_HAZ, 3'b000, 3'b000);
    push(MODE_HAZ, 3'b111, 3'b111);
    expect_steps("haz_sw", 2, 4);
    HAZ_N = 1'b1;
    push(MODE_HAZ, 3'b000, 3'b000);
    push(MODE_IDLE, 3'b000, 3'b000);
    expect_steps("haz_release", 2, 4);
    repeat (5) @(negedge CLK);
    chk("haz_idle", 16'({MODE, LAMP_L, LAMP_R, STEP}), 16'd0);

    // 5: brake overlay during a left sweep and in idle
    LEFT_N = 1'b0;
    push(MODE_LEFT, 3'b001, 3'b000);
    expect_steps("brk_first", 1, 3);
    BRAKE = 1'b1;
    push(MODE_LEFT, 3'b011, 3'b111);
    push(MODE_LEFT, 3'b111, 3'b111);
    push(MODE_LEFT, 3'b000, 3'b111);
    expect_steps("brk_sweep", 3, 4);
    LEFT_N = 1'b1;
    push(MODE_IDLE, 3'b111, 3'b111);
    expect_steps("brk_idle_step", 1, 4);
    repeat (3) @(negedge CLK);
    chk("brk_idle", 16'({MODE, LAMP_L, LAMP_R, STEP}), 16'({2'd0, 3'b111, 3'b111, 1'b0}));
    BRAKE = 1'b0;
    repeat (3) @(negedge CLK);
    chk("brk_off", 16'({MODE, LAMP_L, LAMP_R, STEP}), 16'd0);

    // 6: reset at left k=2, sweep restarts with left still held
    LEFT_N = 1'b0;
    push(MODE_LEFT, 3'b001, 3'b000);
    expect_steps("rst_first", 1, 3);
    push(MODE_LEFT, 3'b011, 3'b000);
    expect_steps("rst_k2", 1, 4);
    RESET = 1'b1;
    @(negedge CLK);
    chk("rst_mid", 16'({MODE, LAMP_L, LAMP_R, STEP}), 16'd0);
    RESET = 1'b0;
    push(MODE_LEFT, 3'b001, 3'b000);
    expect_steps("rst_restart", 1, 3);
    push(MODE_LEFT, 3'b011, 3'b000);
    expect_steps("rst_resweep", 1, 4);
    LEFT_N = 1'b1;
    push(MODE_IDLE, 3'b000, 3'b000);
    expect_steps("rst_release", 1, 4);

    chk("queue_empty", 16'(exp_q.size()), 16'd0);

    // Final report
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
